// File: rtl/wb_regfile_sched.sv
// Writeback scheduler: serialises up to two register writes per committed instruction
// onto a single register-file write port, and forwards pending values to decode.
module wb_regfile_sched #(
   parameter logic [3:0] RNONE = 4'hF
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        valid_i,
   input  logic [3:0]  dstE_i,
   input  logic [63:0] valE_i,
   input  logic [3:0]  dstM_i,
   input  logic [63:0] valM_i,
   output logic        ready_o,
   output logic        rf_we_o,
   output logic [3:0]  rf_waddr_o,
   output logic [63:0] rf_wdata_o,
   input  logic [3:0]  srcA_i,
   input  logic [3:0]  srcB_i,
   output logic        fwdA_hit_o,
   output logic [63:0] fwdA_data_o,
   output logic        fwdB_hit_o,
   output logic [63:0] fwdB_data_o,
   output logic [15:0] wr_count_o
);

   localparam int unsigned AW = 4;
   localparam int unsigned DW = 64;
   localparam int unsigned CW = 16;

   typedef enum logic {IDLE, DRAIN} state_t;

   state_t          state_q, state_d;
   logic            we_q, we_d;
   logic [AW-1:0]   waddr_q, waddr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [AW-1:0]   pend_addr_q, pend_addr_d;
   logic [DW-1:0]   pend_data_q, pend_data_d;
   logic [CW-1:0]   wr_count_q, wr_count_d;

   logic            need_e, need_m;

   // A shared destination collapses to the M write only (e.g. popq %rsp).
   always_comb begin
      need_m = (dstM_i != RNONE);
      need_e = (dstE_i != RNONE) && !(need_m && (dstE_i == dstM_i));
   end

   always_comb begin
      state_d     = state_q;
      we_d        = 1'b0;
      waddr_d     = RNONE;
      wdata_d     = '0;
      pend_addr_d = pend_addr_q;
      pend_data_d = pend_data_q;

      case (state_q)
         IDLE: begin
            if (valid_i) begin
               if (need_e && need_m) begin
                  we_d        = 1'b1;
                  waddr_d     = dstE_i;
                  wdata_d     = valE_i;
                  pend_addr_d = dstM_i;
                  pend_data_d = valM_i;
                  state_d     = DRAIN;
               end else if (need_e) begin
                  we_d    = 1'b1;
                  waddr_d = dstE_i;
                  wdata_d = valE_i;
               end else if (need_m) begin
                  we_d    = 1'b1;
                  waddr_d = dstM_i;
                  wdata_d = valM_i;
               end
            end
         end
         DRAIN: begin
            we_d        = 1'b1;
            waddr_d     = pend_addr_q;
            wdata_d     = pend_data_q;
            pend_addr_d = RNONE;
            pend_data_d = '0;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase

      wr_count_d = we_d ? (wr_count_q + CW'(1)) : wr_count_q;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         waddr_q     <= RNONE;
         wdata_q     <= '0;
         pend_addr_q <= RNONE;
         pend_data_q <= '0;
         wr_count_q  <= '0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         pend_addr_q <= pend_addr_d;
         pend_data_q <= pend_data_d;
         wr_count_q  <= wr_count_d;
      end
   end

   // Pending M write is the newest value, so it takes priority over the write port.
   function automatic logic [DW:0] fwd_lookup(
      input logic [AW-1:0] src,
      input logic          drain,
      input logic [AW-1:0] paddr,
      input logic [DW-1:0] pdata,
      input logic          we,
      input logic [AW-1:0] waddr,
      input logic [DW-1:0] wdata
   );
      logic [DW:0] r;
      r = '0;
      if (src != RNONE) begin
         if (drain && (paddr == src))   r = {1'b1, pdata};
         else if (we && (waddr == src)) r = {1'b1, wdata};
      end
      return r;
   endfunction

   logic [DW:0] fwd_a, fwd_b;

   always_comb begin
      fwd_a = fwd_lookup(srcA_i, state_q == DRAIN, pend_addr_q, pend_data_q,
                         we_q, waddr_q, wdata_q);
      fwd_b = fwd_lookup(srcB_i, state_q == DRAIN, pend_addr_q, pend_data_q,
                         we_q, waddr_q, wdata_q);
   end

   assign ready_o     = (state_q == IDLE);
   assign rf_we_o     = we_q;
   assign rf_waddr_o  = waddr_q;
   assign rf_wdata_o  = wdata_q;
   assign fwdA_hit_o  = fwd_a[DW];
   assign fwdA_data_o = fwd_a[DW-1:0];
   assign fwdB_hit_o  = fwd_b[DW];
   assign fwdB_data_o = fwd_b[DW-1:0];
   assign wr_count_o  = wr_count_q;

endmodule

// File: tb/tb_wb_regfile_sched.sv
// Bench for wb_regfile_sched: queue-based write model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_wb_regfile_sched;

   localparam logic [3:0] RN = 4'hF;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid;
   logic [3:0]  dstE, dstM, srcA, srcB;
   logic [63:0] valE, valM;
   logic        ready, we, fa_hit, fb_hit;
   logic [3:0]  waddr;
   logic [63:0] wdata, fa_data, fb_data;
   logic [15:0] cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb_regfile_sched #(.RNONE(RN)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid),
      .dstE_i(dstE), .valE_i(valE), .dstM_i(dstM), .valM_i(valM),
      .ready_o(ready), .rf_we_o(we), .rf_waddr_o(waddr), .rf_wdata_o(wdata),
      .srcA_i(srcA), .srcB_i(srcB),
      .fwdA_hit_o(fa_hit), .fwdA_data_o(fa_data),
      .fwdB_hit_o(fb_hit), .fwdB_data_o(fb_data),
      .wr_count_o(cnt)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: every accepted instruction queues its writes (E first); one write leaves per edge.
   typedef struct {
      logic [3:0]  a;
      logic [63:0] d;
   } wr_t;

   wr_t         wq[$];
   wr_t         w;
   logic        m_we;
   logic [3:0]  m_addr;
   logic [63:0] m_data;
   logic [15:0] m_cnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wq.delete();
         m_we = 1'b0; m_addr = RN; m_data = '0; m_cnt = '0;
      end else begin
         if (wq.size() == 0 && valid) begin
            if (dstE != RN && dstE != dstM) begin w.a = dstE; w.d = valE; wq.push_back(w); end
            if (dstM != RN) begin w.a = dstM; w.d = valM; wq.push_back(w); end
         end
         if (wq.size() > 0) begin
            w = wq.pop_front();
            m_we = 1'b1; m_addr = w.a; m_data = w.d; m_cnt = m_cnt + 16'd1;
         end else begin
            m_we = 1'b0; m_addr = RN; m_data = '0;
         end
      end
   end

   task automatic model_fwd(input logic [3:0] src, output logic hit, output logic [63:0] d);
      hit = 1'b0; d = '0;
      if (src != RN) begin
         if (wq.size() > 0 && wq[0].a == src) begin hit = 1'b1; d = wq[0].d; end
         else if (m_we && m_addr == src)      begin hit = 1'b1; d = m_data; end
      end
   endtask

   always @(negedge clk) begin
      logic        eh;
      logic [63:0] ed;
      chk("ready", 64'(ready), 64'(wq.size() == 0));
      chk("rf_we", 64'(we), 64'(m_we));
      chk("rf_waddr", 64'(waddr), 64'(m_addr));
      chk("rf_wdata", wdata, m_data);
      chk("wr_count", 64'(cnt), 64'(m_cnt));
      model_fwd(srcA, eh, ed);
      chk("fwdA_hit", 64'(fa_hit), 64'(eh));
      chk("fwdA_data", fa_data, ed);
      model_fwd(srcB, eh, ed);
      chk("fwdB_hit", 64'(fb_hit), 64'(eh));
      chk("fwdB_data", fb_data, ed);
   end

   task automatic set_in(input logic v, input logic [3:0] de, input logic [63:0] ve,
                         input logic [3:0] dm, input logic [63:0] vm);
      valid = v; dstE = de; valE = ve; dstM = dm; valM = vm;
   endtask

   task automatic edge2();
      @(posedge clk); #2;
   endtask

   initial begin
      rst_n = 1'b0;
      set_in(1'b0, RN, '0, RN, '0);
      srcA = RN; srcB = RN;
      #12;
      chk("rst_we", 64'(we), 64'd0);
      chk("rst_addr", 64'(waddr), 64'hF);
      chk("rst_data", wdata, 64'd0);
      chk("rst_cnt", 64'(cnt), 64'd0);
      chk("rst_ready", 64'(ready), 64'd1);
      @(negedge clk); rst_n = 1'b1;
      edge2();

      // Single E write
      set_in(1'b1, 4'd3, 64'h11, RN, '0);
      edge2(); valid = 1'b0;
      chk("single_we", 64'(we), 64'd1);
      chk("single_addr", 64'(waddr), 64'd3);
      chk("single_data", wdata, 64'h11);
      chk("single_ready", 64'(ready), 64'd1);
      chk("single_cnt", 64'(cnt), 64'd1);

      // Dual write with forwarding during drain
      set_in(1'b1, 4'd4, 64'h20, 4'd5, 64'h30);
      srcA = 4'd5; srcB = 4'd4;
      edge2();
      chk("dual1_addr", 64'(waddr), 64'd4);
      chk("dual1_data", wdata, 64'h20);
      chk("dual1_ready", 64'(ready), 64'd0);
      chk("fwdA_pend_hit", 64'(fa_hit), 64'd1);
      chk("fwdA_pend_data", fa_data, 64'h30);
      chk("fwdB_port_hit", 64'(fb_hit), 64'd1);
      chk("fwdB_port_data", fb_data, 64'h20);
      srcA = RN; #1;
      chk("fwdA_none_hit", 64'(fa_hit), 64'd0);
      chk("fwdA_none_data", fa_data, 64'd0);
      edge2(); valid = 1'b0;
      chk("dual2_addr", 64'(waddr), 64'd5);
      chk("dual2_data", wdata, 64'h30);
      chk("dual2_ready", 64'(ready), 64'd1);
      chk("dual2_cnt", 64'(cnt), 64'd3);

      // Collapse: shared destination keeps only the M value
      set_in(1'b1, 4'd4, 64'h100, 4'd4, 64'hAB);
      edge2(); valid = 1'b0;
      chk("coll_addr", 64'(waddr), 64'd4);
      chk("coll_data", wdata, 64'hAB);
      chk("coll_cnt", 64'(cnt), 64'd4);
      edge2();
      chk("coll_after_we", 64'(we), 64'd0);

      // Back-to-back mix: singles, M-only, no-dest, dual, srcs tracking recent writes
      for (int i = 0; i < 24; i++) begin
         case (i % 4)
            0: set_in(1'b1, 4'(i % 15), 64'(i * 3 + 1), RN, '0);
            1: set_in(1'b1, RN, '0, 4'((i + 2) % 15), 64'(i * 7 + 5));
            2: set_in(1'b1, RN, 64'h55, RN, 64'h66);
            default: set_in(1'b1, 4'(i % 15), 64'(i + 100), 4'((i + 1) % 15), 64'(i + 200));
         endcase
         srcA = 4'((i + 1) % 16); srcB = 4'(i % 15);
         @(posedge clk); #1;
         while (!ready) begin @(posedge clk); #1; end
      end
      valid = 1'b0;
      edge2(); edge2();

      // Reset asserted mid-drain drops the pending write to 9
      set_in(1'b1, 4'd8, 64'h88, 4'd9, 64'h99);
      srcA = 4'd9; srcB = RN;
      @(posedge clk); #1; valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_we", 64'(we), 64'd0);
      chk("mid_rst_addr", 64'(waddr), 64'hF);
      chk("mid_rst_data", wdata, 64'd0);
      chk("mid_rst_cnt", 64'(cnt), 64'd0);
      chk("mid_rst_ready", 64'(ready), 64'd1);
      chk("mid_rst_fwd", 64'(fa_hit), 64'd0);
      edge2(); rst_n = 1'b1;
      edge2();
      chk("post_rst_we", 64'(we), 64'd0);
      edge2();
      chk("post_rst_we2", 64'(we), 64'd0);
      chk("post_rst_cnt", 64'(cnt), 64'd0);

      // Counter wrap after 65536 writes
      set_in(1'b1, 4'd1, 64'h1, RN, '0);
      srcA = RN; srcB = RN;
      repeat (65536) @(posedge clk);
      #2 valid = 1'b0;
      chk("wrap_cnt", 64'(cnt), 64'd0);
      chk("wrap_we", 64'(we), 64'd1);
      edge2();
      chk("wrap_idle_cnt", 64'(cnt), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
